sixty_down: RTL and testbench



---
 rtl/sixty_pkg.sv | 19 +
 rtl/bcd_down_digit.sv | 40 ++++
 rtl/sixty_down.sv | 124 ++++++++++++
 tb/tb_sixty_down.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sixty_pkg.sv
// Shared definitions for the mod-60 BCD countdown timer.
//   TENS_W / ONES_W : digit widths
//   MAX_TENS / MAX_ONES : largest legal value of each digit
//   state_t : sequencing states of the timer FSM
package sixty_pkg;

  localparam int TENS_W   = 3;
  localparam int ONES_W   = 4;
  localparam int MAX_TENS = 5;
  localparam int MAX_ONES = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit.
//   clk, rst : clock, synchronous active-high reset (q -> 0)
//   dec      : decrement; 0 wraps to MAX
//   ld       : load ld_val (clamped to MAX), has priority over dec
//   ld_val   : value to load
//   q        : current digit
//   zero     : q == 0, used as the borrow into the next digit
module bcd_down_digit #(
  parameter int W   = 4,
  parameter int MAX = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dec,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] q,
  output logic         zero
);

  localparam logic [W-1:0] MAX_V = W'(MAX);
  localparam logic [W-1:0] ONE_V = W'(1);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (ld) begin
      // clamp so the digit can never leave its legal range
      r_q <= (ld_val > MAX_V) ? MAX_V : ld_val;
    end else if (dec) begin
      r_q <= (r_q == '0) ? MAX_V : (r_q - ONE_V);
    end
  end

  assign q    = r_q;
  assign zero = (r_q == '0);

endmodule

// File: rtl/sixty_down.sv
// Two-digit BCD mod-60 countdown timer with idle/run/pause/done sequencing.
//   clk, rst         : clock, synchronous active-high reset
//   tick             : count-enable strobe, one decrement per tick in RUN
//   start/stop/load  : control strobes, priority load > stop > start > tick
//   ld_tens, ld_ones : preset digits (clamped to 5 / 9)
//   tens, ones       : current count
//   borrow           : one-cycle pulse when a tick arrives at count 00
//   running, done    : registered state decodes
//
// state | meaning
// IDLE  | stopped, waiting for start; loads land here
// RUN   | counting on tick
// PAUSE | count held, start resumes
// DONE  | count expired at 00 (only without WRAP), waiting for load
module sixty_down
  import sixty_pkg::*;
#(
  parameter bit                 WRAP        = 1'b0,
  parameter logic [TENS_W-1:0]  RELOAD_TENS = 3'd5,
  parameter logic [ONES_W-1:0]  RELOAD_ONES = 4'd9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  input  logic              stop,
  input  logic              load,
  input  logic [TENS_W-1:0] ld_tens,
  input  logic [ONES_W-1:0] ld_ones,
  output logic [TENS_W-1:0] tens,
  output logic [ONES_W-1:0] ones,
  output logic              borrow,
  output logic              running,
  output logic              done
);

  state_t r_state;
  state_t w_state_nxt;
  logic   r_borrow;
  logic   r_running;
  logic   r_done;

  logic [TENS_W-1:0] w_tens;
  logic [ONES_W-1:0] w_ones;
  logic              w_tens_zero;
  logic              w_ones_zero;
  logic              w_cnt_zero;
  logic              w_run_tick;
  logic              w_wrap_ld;
  logic              w_ld;
  logic              w_dec_ones;
  logic              w_dec_tens;
  logic [TENS_W-1:0] w_ld_tens;
  logic [ONES_W-1:0] w_ld_ones;

  assign w_cnt_zero = w_tens_zero & w_ones_zero;
  // load and stop both swallow a simultaneous tick
  assign w_run_tick = (r_state == RUN) & tick & ~load & ~stop;
  assign w_wrap_ld  = w_run_tick & w_cnt_zero & WRAP;
  assign w_ld       = load | w_wrap_ld;
  assign w_ld_tens  = load ? ld_tens : RELOAD_TENS;
  assign w_ld_ones  = load ? ld_ones : RELOAD_ONES;
  // at 00 the tick is a borrow (reload or expire), never a decrement
  assign w_dec_ones = w_run_tick & ~w_cnt_zero;
  assign w_dec_tens = w_dec_ones & w_ones_zero;

  bcd_down_digit #(.W(ONES_W), .MAX(MAX_ONES)) u_ones (
    .clk    (clk),
    .rst    (rst),
    .dec    (w_dec_ones),
    .ld     (w_ld),
    .ld_val (w_ld_ones),
    .q      (w_ones),
    .zero   (w_ones_zero)
  );

  bcd_down_digit #(.W(TENS_W), .MAX(MAX_TENS)) u_tens (
    .clk    (clk),
    .rst    (rst),
    .dec    (w_dec_tens),
    .ld     (w_ld),
    .ld_val (w_ld_tens),
    .q      (w_tens),
    .zero   (w_tens_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (load) begin
      w_state_nxt = IDLE;
    end else if (stop) begin
      if (r_state == RUN) w_state_nxt = PAUSE;
    end else if (start) begin
      case (r_state)
        IDLE:    w_state_nxt = w_cnt_zero ? DONE : RUN;
        PAUSE:   w_state_nxt = RUN;
        default: w_state_nxt = r_state;
      endcase
    end else if (w_run_tick && w_cnt_zero && !WRAP) begin
      w_state_nxt = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_borrow  <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_borrow  <= w_run_tick & w_cnt_zero;
      r_running <= (w_state_nxt == RUN);
      r_done    <= (w_state_nxt == DONE);
    end
  end

  assign tens    = w_tens;
  assign ones    = w_ones;
  assign borrow  = r_borrow;
  assign running = r_running;
  assign done    = r_done;

endmodule

// File: tb/tb_sixty_down.sv
module tb_sixty_down;

  logic       clk = 1'b0;
  logic       rst, tick, start, stop, load;
  logic [2:0] ld_tens;
  logic [3:0] ld_ones;
  logic [2:0] tens_o [2];
  logic [3:0] ones_o [2];
  logic       borrow_o [2];
  logic       running_o [2];
  logic       done_o [2];

  int checks = 0;
  int errors = 0;

  // reference model: count as a plain integer 0..59, state 0 idle 1 run 2 pause 3 done
  int cnt [2];
  int st  [2];
  int mb  [2];
  int wrap_of [2] = '{0, 1};

  always #5 clk = ~clk;

  sixty_down #(.WRAP(1'b0), .RELOAD_TENS(3'd5), .RELOAD_ONES(4'd9)) u_nw (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .load(load),
    .ld_tens(ld_tens), .ld_ones(ld_ones),
    .tens(tens_o[0]), .ones(ones_o[0]), .borrow(borrow_o[0]),
    .running(running_o[0]), .done(done_o[0])
  );

  sixty_down #(.WRAP(1'b1), .RELOAD_TENS(3'd5), .RELOAD_ONES(4'd9)) u_w (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .load(load),
    .ld_tens(ld_tens), .ld_ones(ld_ones),
    .tens(tens_o[1]), .ones(ones_o[1]), .borrow(borrow_o[1]),
    .running(running_o[1]), .done(done_o[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model(input int k, input bit r, t, s, p, l, input int lt, input int lo);
    mb[k] = 0;
    if (r) begin
      cnt[k] = 0; st[k] = 0;
    end else if (l) begin
      cnt[k] = ((lt > 5) ? 5 : lt) * 10 + ((lo > 9) ? 9 : lo);
      st[k]  = 0;
    end else if (p) begin
      if (st[k] == 1) st[k] = 2;
    end else if (s && st[k] != 1) begin
      if (st[k] == 0) st[k] = (cnt[k] != 0) ? 1 : 3;
      else if (st[k] == 2) st[k] = 1;
    end else if (t && st[k] == 1) begin
      if (cnt[k] == 0) begin
        mb[k] = 1;
        if (wrap_of[k] != 0) cnt[k] = 59;
        else st[k] = 3;
      end else begin
        cnt[k] = cnt[k] - 1;
      end
    end
  endtask

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("tens[%0d]", k),    int'(tens_o[k]),    cnt[k] / 10);
      chk($sformatf("ones[%0d]", k),    int'(ones_o[k]),    cnt[k] % 10);
      chk($sformatf("borrow[%0d]", k),  int'(borrow_o[k]),  mb[k]);
      chk($sformatf("running[%0d]", k), int'(running_o[k]), (st[k] == 1) ? 1 : 0);
      chk($sformatf("done[%0d]", k),    int'(done_o[k]),    (st[k] == 3) ? 1 : 0);
    end
  endtask

  // drive one cycle of inputs, advance the model, then check after the edge
  task automatic step(input bit r, t, s, p, l, input int lt = 0, input int lo = 0);
    rst = r; tick = t; start = s; stop = p; load = l;
    ld_tens = 3'(lt); ld_ones = 4'(lo);
    for (int k = 0; k < 2; k++) model(k, r, t, s, p, l, lt, lo);
    @(negedge clk);
    compare();
  endtask

  initial begin
    int nb;
    bit r, t, s, p, l;
    step(1, 0, 0, 0, 0);

    // reset while running at 37
    step(0, 0, 0, 0, 1, 3, 7);
    step(0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("rst37_tens", int'(tens_o[0]), 0);
    chk("rst37_ones", int'(ones_o[0]), 0);
    chk("rst37_running", int'(running_o[0]), 0);
    chk("rst37_done", int'(done_o[0]), 0);

    // 03 down to expiry
    step(0, 0, 0, 0, 1, 0, 3);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("to00_ones", int'(ones_o[0]), 0);
    chk("to00_borrow", int'(borrow_o[0]), 0);
    step(0, 1, 0, 0, 0);
    chk("expire_borrow", int'(borrow_o[0]), 1);
    chk("expire_done", int'(done_o[0]), 1);
    chk("wrap_tens", int'(tens_o[1]), 5);
    step(0, 1, 0, 0, 0);
    chk("hold_borrow", int'(borrow_o[0]), 0);
    chk("hold_ones", int'(ones_o[0]), 0);

    // 10 -> 09
    step(0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("09_tens", int'(tens_o[0]), 0);
    chk("09_ones", int'(ones_o[0]), 9);
    chk("09_borrow", int'(borrow_o[0]), 0);

    // start at 00 goes straight to DONE; 01 wraps to 59
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("start00_done", int'(done_o[1]), 1);
    chk("start00_borrow", int'(borrow_o[1]), 0);
    step(0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("wrap59_ones", int'(ones_o[1]), 9);
    chk("wrap59_borrow", int'(borrow_o[1]), 1);
    chk("wrap59_running", int'(running_o[1]), 1);
    step(0, 0, 0, 0, 0);
    chk("wrap_borrow_once", int'(borrow_o[1]), 0);

    // pause/resume at 25
    step(0, 0, 0, 0, 1, 2, 5);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 1, 0);
    chk("pause_ones", int'(ones_o[0]), 5);
    chk("pause_running", int'(running_o[0]), 0);
    step(0, 1, 1, 0, 0);
    chk("resume_ones", int'(ones_o[0]), 5);
    chk("resume_running", int'(running_o[0]), 1);
    step(0, 1, 0, 0, 0);
    chk("resume_24", int'(ones_o[0]), 4);

    // clamped load and a full 60-tick lap
    step(0, 0, 0, 0, 1, 7, 12);
    chk("clamp_tens", int'(tens_o[0]), 5);
    chk("clamp_ones", int'(ones_o[0]), 9);
    step(0, 0, 1, 0, 0);
    nb = 0;
    for (int i = 0; i < 60; i++) begin
      step(0, 1, 0, 0, 0);
      if (borrow_o[1]) nb++;
    end
    chk("lap_borrows", nb, 1);
    chk("lap_tens", int'(tens_o[1]), 5);
    chk("lap_ones", int'(ones_o[1]), 9);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(99) == 0);
      l = ($urandom_range(19) == 0);
      p = ($urandom_range(14) == 0);
      s = !p && ($urandom_range(7) == 0) && st[0] != 1 && st[1] != 1;
      t = $urandom_range(1);
      step(r, t, s, p, l, int'($urandom_range(7)), int'($urandom_range(15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
